custom_subtractor55_8_seq: RTL
==============================

// Module: custom_subtractor55_8_seq
// PURPOSE
//  Multi-cycle unsigned subtractor: Diff = A - zero_extend(B), 55-bit minuend, 47-bit subtrahend.
//  Inverse companion of the 55x47 zero-extending adder.
//  Resolves the borrow chain CHUNK bits per cycle to keep the critical path short.
//  Sits in the mantissa datapath for alignment/normalisation subtraction; valid/ready on both sides.
// PARAMETERS
//  A_WIDTH  55  minuend width; also the width of Diff
//  B_WIDTH  47  subtrahend width; zero-extended by A_WIDTH-B_WIDTH (8) bits
//  CHUNK    8   bits resolved per cycle; NCHUNK = ceil(A_WIDTH/CHUNK) = 7, last chunk is 7 bits
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands valid
//  in_ready   out  1        block can accept operands
//  A          in   A_WIDTH  minuend
//  B          in   B_WIDTH  subtrahend (unsigned)
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  Diff       out  A_WIDTH  A - B, modulo 2^A_WIDTH
//  borrow     out  1        1 when B > A (result underflowed)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; Diff=0; borrow=0; chunk index=0.
//  FSM states and transitions:
//   IDLE: in_ready=1. On in_valid&in_ready, register A and {8'b0,B}, clear borrow, index=0 -> BUSY.
//   BUSY: in_ready=0. Each cycle, chunk[index] = A_chunk - B_chunk - borrow_in, written into Diff;
//         borrow_in for the next chunk = borrow out of this chunk. After chunk NCHUNK-1 -> DONE.
//   DONE: out_valid=1. Diff and borrow held stable. On out_ready -> IDLE.
//  Latency: out_valid is high NCHUNK cycles after the accepting edge (7 by default).
//  Throughput: one operation per NCHUNK+2 cycles.
//  in_ready is high in IDLE only; inputs are ignored outside IDLE.
//  The last chunk is A_WIDTH-(NCHUNK-1)*CHUNK bits wide. Its borrow-out is the final borrow.
//  Diff is written only at the chunk boundaries of the current operation.
//  Intermediate Diff is not observable as valid (out_valid=0).
//  out_ready while out_valid=0 has no effect.
//  Backpressure: DONE is held indefinitely until out_ready=1.
//  rst_n asserted mid-operation aborts it immediately and returns all outputs to reset values.
//  Arithmetic: Diff = (A - B) mod 2^55; borrow = (B > A); A == B gives Diff=0, borrow=0.
// CONFIGURATION
//  CUSTOM_SUB_SATURATE_EN defined:
//   - On entry to DONE with borrow=1, Diff is forced to 0.
//   - borrow still reports the underflow.
//  Not defined: Diff is the wrapped two's-complement result; no clamping.
// TESTING
//  A=5, B=3 -> after 7 cycles out_valid=1, Diff=2, borrow=0.
//  A=0, B=1 -> Diff=0x7FFFFFFFFFFFFF, borrow=1.
//     With CUSTOM_SUB_SATURATE_EN: Diff=0, borrow=1.
//  A=0x7FFFFFFFFFFFFF, B=0x7FFFFFFFFFFF -> Diff=0x7F800000000000, borrow=0.
//  A=0x100, B=1 (borrow crosses chunk 0->1) -> Diff=0xFF, borrow=0.
//  out_ready held 0 for 5 cycles in DONE -> out_valid, Diff and borrow stable;
//     in_valid pulses ignored; one cycle after out_ready=1, in_ready=1.
//  rst_n pulsed low during BUSY cycle 3 -> out_valid=0, Diff=0, in_ready=1;
//     next operation A=9, B=9 -> Diff=0, borrow=0.

Source files
------------

// File: rtl/custom_subtractor55_8_seq_if.sv
// rtl/custom_subtractor55_8_seq_if.sv - operand/result handshake bundle for the chunked subtractor
//
// Purpose : groups the operand (request) and result (response) handshakes of
//           custom_subtractor55_8_seq so producer and consumer attach through one port.
// Signals :
//   in_valid   producer -> block   operands valid
//   in_ready   block -> producer   block can accept operands
//   A          producer -> block   minuend, A_WIDTH bits
//   B          producer -> block   subtrahend, B_WIDTH bits, unsigned
//   out_valid  block -> consumer   result valid
//   out_ready  consumer -> block   consumer accepts result
//   Diff       block -> consumer   A - B modulo 2^A_WIDTH
//   borrow     block -> consumer   1 when B > A
// Modports: master = producer/consumer side, slave = subtractor side.

interface custom_subtractor55_8_seq_if #(
  parameter int A_WIDTH = 55,
  parameter int B_WIDTH = 47
);

  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] A;
  logic [B_WIDTH-1:0] B;
  logic               out_valid;
  logic               out_ready;
  logic [A_WIDTH-1:0] Diff;
  logic               borrow;

  modport master (
    output in_valid,
    input  in_ready,
    output A,
    output B,
    input  out_valid,
    output out_ready,
    input  Diff,
    input  borrow
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  A,
    input  B,
    output out_valid,
    input  out_ready,
    output Diff,
    output borrow
  );

endinterface

// File: rtl/custom_subtractor55_8_seq.sv
// rtl/custom_subtractor55_8_seq.sv - multi-cycle unsigned subtractor, borrow chain resolved CHUNK bits per cycle
//
// Purpose : Diff = A - zero_extend(B) modulo 2^A_WIDTH, borrow = (B > A).
//           The borrow ripples through one CHUNK-bit slice per clock so the
//           critical path is a single CHUNK-bit subtract. Operation is
//           IDLE (accept) -> BUSY (NCHUNK slices) -> DONE (hold until taken).
// Ports   :
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   bus       slave modport of custom_subtractor55_8_seq_if
//             (in_valid/in_ready/A/B in, out_valid/out_ready/Diff/borrow out)
// Config  : CUSTOM_SUB_SATURATE_EN - when defined, an underflowing result is
//           clamped to Diff=0 on entry to DONE; borrow still reports it.
//           When undefined, Diff is the wrapped two's-complement result.

module custom_subtractor55_8_seq #(
  parameter int A_WIDTH = 55,
  parameter int B_WIDTH = 47,
  parameter int CHUNK   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  custom_subtractor55_8_seq_if.slave bus
);

  localparam int NCHUNK = (A_WIDTH + CHUNK - 1) / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SH_W   = $clog2(NCHUNK * CHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [A_WIDTH-1:0] a_q;
  logic [A_WIDTH-1:0] b_q;        // subtrahend already zero-extended to A_WIDTH
  logic [A_WIDTH-1:0] diff_q;
  logic               borrow_q;   // running borrow while BUSY, final borrow in DONE
  logic [IDX_W-1:0]   idx_q;
  logic               in_ready_q;
  logic               out_valid_q;

  // Slice datapath for the chunk selected by idx_q.
  logic [SH_W-1:0]    shamt;
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_res;
  logic [A_WIDTH-1:0] chunk_mask;
  logic [A_WIDTH-1:0] chunk_ins;
  logic [A_WIDTH-1:0] diff_d;
  logic               borrow_d;

  always_comb begin
    shamt     = SH_W'(idx_q) * SH_W'(CHUNK);
    // Shifting right leaves zeros above the top of the operand, so the short
    // final slice is naturally zero-padded to CHUNK bits. With both padded
    // bits at zero, the borrow out of the padded subtract equals the borrow
    // out of the true short slice.
    a_chunk   = CHUNK'(a_q >> shamt);
    b_chunk   = CHUNK'(b_q >> shamt);
    chunk_res = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
    borrow_d  = chunk_res[CHUNK];
    // Bits of the final slice shifted past A_WIDTH simply fall off, which
    // drops the padding bit of the short last chunk.
    chunk_mask = {{(A_WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}} << shamt;
    chunk_ins  = {{(A_WIDTH-CHUNK){1'b0}}, chunk_res[CHUNK-1:0]} << shamt;
    diff_d     = (diff_q & ~chunk_mask) | chunk_ins;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.A;
            b_q        <= {{(A_WIDTH-B_WIDTH){1'b0}}, bus.B};
            borrow_q   <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end

        S_BUSY: begin
          diff_q   <= diff_d;
          borrow_q <= borrow_d;
          if (idx_q == LAST_IDX) begin
`ifdef CUSTOM_SUB_SATURATE_EN
            if (borrow_d) begin
              diff_q <= '0;
            end
`endif
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        S_DONE: begin
          // Result is held until the consumer takes it; no timeout.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Diff      = diff_q;
  assign bus.borrow    = borrow_q;

endmodule
